// File: rtl/bear_range_source_ctrl.sv
// bear_range_source_ctrl
//   Source-selection controller for the bearing/range decode datapath.
//   It watches the external bearing word and the external range sync for
//   activity and regularity. It switches the bearing or synclk source to
//   external only after that source has delivered LOCK_COUNT consecutive good
//   intervals. A synclk release back to the internal source waits for an
//   InsideSynclk rising edge, or gives up after LOSS_TIMEOUT cycles.
//
//   Optional feature macro: BRD_SRC_FAILOVER_EN
//     defined   : a timeout or short interval while external forces a
//                 failover back to ARM, pulses FaultStrobe and bumps FaultCount.
//     undefined : external stays selected until the host drops the request;
//                 ExtOk tracks interval health; FaultStrobe/FaultCount read 0.
//
//   Ports:
//     Clk40M       in   sole clock
//     Reset        in   asynchronous, active-high reset
//     CmdValid     in   one-cycle host command strobe
//     Cmd[1:0]     in   requested source (bit0 bear, bit1 synclk; 1 = external)
//     ExSynclk     in   external synclk, already synchronous to Clk40M
//     InsideSynclk in   internal synclk
//     ExBear[11:0] in   external bearing word
//     Select[1:0]  out  registered source select (bit0 bear, bit1 synclk)
//     ExtOk[1:0]   out  channel is external and its last interval was good
//     FaultStrobe  out  one-cycle pulse on any failover
//     FaultCount   out  saturating failover count
module bear_range_source_ctrl #(
  parameter int unsigned LOSS_TIMEOUT = 40000,
  parameter int unsigned MIN_GAP      = 400,
  parameter int unsigned LOCK_COUNT   = 8
) (
  input  logic        Clk40M,
  input  logic        Reset,
  input  logic        CmdValid,
  input  logic [1:0]  Cmd,
  input  logic        ExSynclk,
  input  logic        InsideSynclk,
  input  logic [11:0] ExBear,
  output logic [1:0]  Select,
  output logic [1:0]  ExtOk,
  output logic        FaultStrobe,
  output logic [7:0]  FaultCount
);

  typedef enum logic [1:0] {ST_IN, ST_ARM, ST_EXT, ST_RELEASE} chan_state_t;

  localparam int unsigned BEAR = 0;
  localparam int unsigned SYNC = 1;
  localparam logic [15:0] LOSS_VAL = 16'(LOSS_TIMEOUT);
  localparam logic [15:0] GAP_VAL  = 16'(MIN_GAP);
  localparam logic [3:0]  LOCK_VAL = 4'(LOCK_COUNT);

  logic [1:0]  req_q;
  logic [11:0] bear_prev_q;
  logic        sync_prev_q;
  logic        inside_prev_q;
  logic [15:0] interval_q [2];
  logic [3:0]  good_q [2];
  logic [1:0]  seen_q;
  logic [1:0]  last_good_q;
  chan_state_t state_q [2];
  logic [15:0] release_q;

  logic [1:0]  req_eff;
  logic [1:0]  event_now;
  logic [1:0]  good_iv;
  logic [1:0]  short_iv;
  logic [1:0]  timeout;
  logic        inside_rise;
  chan_state_t state_d [2];
  logic [3:0]  good_d [2];
  logic [1:0]  seen_d;
  logic [1:0]  last_good_d;
  logic [1:0]  sel_d;
  logic [1:0]  ext_ok_d;
`ifdef BRD_SRC_FAILOVER_EN
  logic [1:0]  fault_d;
`endif

  // A command acts in the cycle it arrives, so IN moves to ARM one cycle
  // after CmdValid. The bear channel has no minimum gap, so it can never
  // see a short interval.
  always_comb begin
    req_eff      = CmdValid ? Cmd : req_q;
    event_now[0] = (ExBear != bear_prev_q);
    event_now[1] = ExSynclk & ~sync_prev_q;
    inside_rise  = InsideSynclk & ~inside_prev_q;
    good_iv      = '0;
    short_iv     = '0;
    timeout      = '0;
    for (int c = 0; c < 2; c++) begin
      timeout[c]  = (interval_q[c] == LOSS_VAL);
      good_iv[c]  = event_now[c] && (interval_q[c] < LOSS_VAL) &&
                    ((c != SYNC) || (interval_q[c] >= GAP_VAL));
      short_iv[c] = event_now[c] && (c == SYNC) && (interval_q[c] < GAP_VAL);
    end
  end

  // Per-channel state machine. In ARM, the first event after entry only
  // starts a measurement. A timeout is a level condition while the interval
  // counter sits saturated. So after a loss, the first returning event also
  // clears the good count, and the relock needs LOCK_COUNT fresh intervals.
  // Select stays high through RELEASE so the synclk switch-back can wait for
  // an internal edge.
  always_comb begin
    seen_d      = seen_q;
    last_good_d = last_good_q;
    sel_d       = '0;
    ext_ok_d    = '0;
`ifdef BRD_SRC_FAILOVER_EN
    fault_d     = '0;
`endif
    for (int c = 0; c < 2; c++) begin
      state_d[c] = state_q[c];
      good_d[c]  = good_q[c];
      if (good_iv[c])
        last_good_d[c] = 1'b1;
      else if (short_iv[c] || timeout[c])
        last_good_d[c] = 1'b0;

      case (state_q[c])
        ST_IN: begin
          if (req_eff[c]) begin
            state_d[c] = ST_ARM;
            good_d[c]  = '0;
            seen_d[c]  = 1'b0;
          end
        end
        ST_ARM: begin
          if (!req_eff[c])
            state_d[c] = ST_IN;
          else if (!seen_q[c])
            seen_d[c] = event_now[c];
          else if (short_iv[c] || timeout[c])
            good_d[c] = '0;
          else if (good_iv[c]) begin
            if ((good_q[c] + 4'd1) == LOCK_VAL) begin
              state_d[c] = ST_EXT;
              good_d[c]  = '0;
            end else begin
              good_d[c] = good_q[c] + 4'd1;
            end
          end
        end
        ST_EXT: begin
`ifdef BRD_SRC_FAILOVER_EN
          if (short_iv[c] || timeout[c]) begin
            state_d[c] = ST_ARM;
            good_d[c]  = '0;
            fault_d[c] = 1'b1;
          end else
`endif
          if (!req_eff[c])
            state_d[c] = (c == SYNC) ? ST_RELEASE : ST_IN;
        end
        ST_RELEASE: begin
          if (req_eff[c])
            state_d[c] = ST_EXT;
          else if (inside_rise || (release_q == LOSS_VAL))
            state_d[c] = ST_IN;
        end
        default: state_d[c] = ST_IN;
      endcase

      sel_d[c]    = (state_d[c] == ST_EXT) || (state_d[c] == ST_RELEASE);
      ext_ok_d[c] = (state_d[c] == ST_EXT) && last_good_d[c];
    end
  end

  // State, history, interval counters and the registered outputs. The
  // interval counter clears on every event and otherwise saturates at
  // LOSS_TIMEOUT. The release wait counts only while synclk sits in RELEASE.
  always_ff @(posedge Clk40M or posedge Reset) begin
    if (Reset) begin
      req_q         <= '0;
      bear_prev_q   <= '0;
      sync_prev_q   <= 1'b0;
      inside_prev_q <= 1'b0;
      seen_q        <= '0;
      last_good_q   <= '0;
      release_q     <= '0;
      Select        <= '0;
      ExtOk         <= '0;
      for (int c = 0; c < 2; c++) begin
        interval_q[c] <= '0;
        good_q[c]     <= '0;
        state_q[c]    <= ST_IN;
      end
    end else begin
      if (CmdValid)
        req_q <= Cmd;
      bear_prev_q   <= ExBear;
      sync_prev_q   <= ExSynclk;
      inside_prev_q <= InsideSynclk;
      seen_q        <= seen_d;
      last_good_q   <= last_good_d;
      Select        <= sel_d;
      ExtOk         <= ext_ok_d;
      for (int c = 0; c < 2; c++) begin
        if (event_now[c])
          interval_q[c] <= '0;
        else if (interval_q[c] != LOSS_VAL)
          interval_q[c] <= interval_q[c] + 16'd1;
        good_q[c]  <= good_d[c];
        state_q[c] <= state_d[c];
      end
      if (state_q[SYNC] != ST_RELEASE)
        release_q <= '0;
      else if (release_q != LOSS_VAL)
        release_q <= release_q + 16'd1;
    end
  end

`ifdef BRD_SRC_FAILOVER_EN
  // Faults on both channels in one cycle count as a single failover.
  always_ff @(posedge Clk40M or posedge Reset) begin
    if (Reset) begin
      FaultStrobe <= 1'b0;
      FaultCount  <= '0;
    end else begin
      FaultStrobe <= |fault_d;
      if ((|fault_d) && (FaultCount != 8'hFF))
        FaultCount <= FaultCount + 8'd1;
    end
  end
`else
  assign FaultStrobe = 1'b0;
  assign FaultCount  = '0;
`endif

endmodule

// File: tb/tb_bear_range_source_ctrl.sv
// Directed bench for bear_range_source_ctrl, using scaled timing parameters
// (timeout 64, minimum gap 16, synclk period 40). Expected values depend on
// whether BRD_SRC_FAILOVER_EN is defined.
module tb_bear_range_source_ctrl;

  localparam int unsigned LOSS   = 64;
  localparam int unsigned GAP    = 16;
  localparam int unsigned LOCK   = 8;
  localparam int          PERIOD = 40;
`ifdef BRD_SRC_FAILOVER_EN
  localparam bit FAILOVER = 1'b1;
`else
  localparam bit FAILOVER = 1'b0;
`endif

  logic        Clk40M = 1'b0;
  logic        Reset;
  logic        CmdValid;
  logic [1:0]  Cmd;
  logic        ExSynclk;
  logic        InsideSynclk;
  logic [11:0] ExBear;
  logic [1:0]  Select;
  logic [1:0]  ExtOk;
  logic        FaultStrobe;
  logic [7:0]  FaultCount;

  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [11:0] bearVal     = 12'd0;

  bear_range_source_ctrl #(
    .LOSS_TIMEOUT(LOSS),
    .MIN_GAP     (GAP),
    .LOCK_COUNT  (LOCK)
  ) dut (
    .Clk40M      (Clk40M),
    .Reset       (Reset),
    .CmdValid    (CmdValid),
    .Cmd         (Cmd),
    .ExSynclk    (ExSynclk),
    .InsideSynclk(InsideSynclk),
    .ExBear      (ExBear),
    .Select      (Select),
    .ExtOk       (ExtOk),
    .FaultStrobe (FaultStrobe),
    .FaultCount  (FaultCount)
  );

  always #5 Clk40M = ~Clk40M;

  task automatic tick();
    @(posedge Clk40M);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic applyStimulus(input logic [1:0] cmdIn);
    CmdValid = 1'b1;
    Cmd      = cmdIn;
    tick();
    CmdValid = 1'b0;
  endtask

  task automatic syncEdge();
    ExSynclk = 1'b1;
    tick();
    ExSynclk = 1'b0;
  endtask

  task automatic bearChange();
    bearVal = bearVal + 12'd1;
    ExBear  = bearVal;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    Reset = 1'b1; CmdValid = 1'b0; Cmd = 2'b00;
    ExSynclk = 1'b0; InsideSynclk = 1'b0; ExBear = 12'd0;
    idle(3);
    checkOutput("reset_select", 8'(Select), 8'h00);
    checkOutput("reset_extok", 8'(ExtOk), 8'h00);
    checkOutput("reset_strobe", 8'(FaultStrobe), 8'h00);
    checkOutput("reset_count", FaultCount, 8'h00);
    Reset = 1'b0;
    idle(2);

    // Reset asserted mid-lock, with synclk in ARM and five good intervals counted
    applyStimulus(2'b10);
    repeat (6) begin syncEdge(); idle(PERIOD - 1); end
    checkOutput("arm_no_select", 8'(Select), 8'h00);
    Reset = 1'b1;
    #1;
    checkOutput("midlock_reset_select", 8'(Select), 8'h00);
    checkOutput("midlock_reset_extok", 8'(ExtOk), 8'h00);
    checkOutput("midlock_reset_count", FaultCount, 8'h00);
    tick();
    Reset = 1'b0;
    idle(2);

    // Fresh synclk lock: Select[1] rises one cycle after the ninth edge
    applyStimulus(2'b10);
    repeat (8) begin syncEdge(); idle(PERIOD - 1); end
    checkOutput("lock_after_8_edges", 8'(Select), 8'h00);
    syncEdge();
    checkOutput("lock_9th_select", 8'(Select), 8'h02);
    checkOutput("lock_9th_extok", 8'(ExtOk), 8'h02);

    // Synclk stops: timeout 64 cycles after the last edge
    idle(64);
    checkOutput("pre_timeout_select", 8'(Select), 8'h02);
    checkOutput("pre_timeout_extok", 8'(ExtOk), 8'h02);
    checkOutput("pre_timeout_strobe", 8'(FaultStrobe), 8'h00);
    tick();
    checkOutput("timeout_select", 8'(Select), FAILOVER ? 8'h00 : 8'h02);
    checkOutput("timeout_extok", 8'(ExtOk), 8'h00);
    checkOutput("timeout_strobe", 8'(FaultStrobe), FAILOVER ? 8'h01 : 8'h00);
    checkOutput("timeout_count", FaultCount, FAILOVER ? 8'h01 : 8'h00);
    tick();
    checkOutput("strobe_one_cycle", 8'(FaultStrobe), 8'h00);
    idle(5);

    // Synclk restarts and relocks after eight good intervals
    syncEdge();
    checkOutput("restart_e1_extok", 8'(ExtOk), 8'h00);
    checkOutput("restart_e1_select", 8'(Select), FAILOVER ? 8'h00 : 8'h02);
    idle(PERIOD - 1);
    syncEdge();
    checkOutput("restart_e2_extok", 8'(ExtOk), FAILOVER ? 8'h00 : 8'h02);
    idle(PERIOD - 1);
    repeat (6) begin syncEdge(); idle(PERIOD - 1); end
    checkOutput("relock_before_9th", 8'(Select), FAILOVER ? 8'h00 : 8'h02);
    syncEdge();
    checkOutput("relock_9th_select", 8'(Select), 8'h02);
    checkOutput("relock_9th_extok", 8'(ExtOk), 8'h02);

    // Bear channel locks on nine word changes
    applyStimulus(2'b11);
    repeat (8) bearChange();
    checkOutput("bear_before_lock", 8'(Select), 8'h02);
    bearChange();
    checkOutput("bear_lock_select", 8'(Select), 8'h03);
    checkOutput("bear_lock_extok", 8'(ExtOk), 8'h03);

    // Release both: bear drops at once, synclk waits for an InsideSynclk edge
    applyStimulus(2'b00);
    checkOutput("release_bear_drop", 8'(Select), 8'h02);
    checkOutput("release_extok", 8'(ExtOk), 8'h00);
    idle(3);
    checkOutput("release_hold", 8'(Select), 8'h02);
    InsideSynclk = 1'b1;
    tick();
    checkOutput("release_inside_edge", 8'(Select), 8'h00);
    InsideSynclk = 1'b0;
    idle(2);

    // Release with InsideSynclk held low ends on the release timeout
    applyStimulus(2'b10);
    repeat (8) begin syncEdge(); idle(PERIOD - 1); end
    syncEdge();
    checkOutput("g_lock_select", 8'(Select), 8'h02);
    applyStimulus(2'b00);
    checkOutput("g_release_start", 8'(Select), 8'h02);
    idle(64);
    checkOutput("g_release_hold", 8'(Select), 8'h02);
    tick();
    checkOutput("g_release_timeout", 8'(Select), 8'h00);
    idle(2);

    // A glitch edge at good=6 clears the count; eight further intervals are needed
    applyStimulus(2'b10);
    repeat (6) begin syncEdge(); idle(PERIOD - 1); end
    syncEdge();
    idle(4);
    syncEdge();
    idle(PERIOD - 6);
    repeat (7) begin syncEdge(); idle(PERIOD - 1); end
    checkOutput("glitch_no_early_lock", 8'(Select), 8'h00);
    syncEdge();
    checkOutput("glitch_lock_8th", 8'(Select), 8'h02);

    // Simultaneous timeout on both channels: a single failover
    applyStimulus(2'b11);
    repeat (8) bearChange();
    checkOutput("joint_bear_prelock", 8'(Select), 8'h02);
    bearChange();
    checkOutput("joint_both_ext", 8'(Select), 8'h03);
    idle(29);
    ExSynclk = 1'b1;
    bearVal  = bearVal + 12'd1;
    ExBear   = bearVal;
    tick();
    ExSynclk = 1'b0;
    idle(64);
    checkOutput("joint_pre_timeout", 8'(Select), 8'h03);
    tick();
    checkOutput("joint_timeout_select", 8'(Select), FAILOVER ? 8'h00 : 8'h03);
    checkOutput("joint_strobe", 8'(FaultStrobe), FAILOVER ? 8'h01 : 8'h00);
    checkOutput("joint_count", FaultCount, FAILOVER ? 8'h02 : 8'h00);
    tick();
    checkOutput("joint_strobe_clear", 8'(FaultStrobe), 8'h00);

    // Repeated bear loss and relock drives FaultCount into saturation
    applyStimulus(2'b01);
    for (int i = 0; i < 300; i++) begin
      repeat (9) bearChange();
      if (i == 0)
        checkOutput("loop_bear_locked", 8'(Select[0]), 8'h01);
      idle(65);
      if (i == 99)
        checkOutput("loop_count_100", FaultCount, FAILOVER ? 8'd102 : 8'd0);
    end
    checkOutput("fault_saturate", FaultCount, FAILOVER ? 8'd255 : 8'd0);
    checkOutput("loop_final_select", 8'(Select), FAILOVER ? 8'h00 : 8'h01);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
